// File: rtl/sha2_eddsa_pkg.sv
// Shared definitions for the EdDSA SHA-2 message-schedule path: FSM encoding,
// sigma rotation/shift amounts per word width, round count and clog2 helpers.
package sha2_eddsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } wsched_state_t;

  localparam int SIG0_ROT_A_32 = 7;
  localparam int SIG0_ROT_B_32 = 18;
  localparam int SIG0_SHR_32   = 3;
  localparam int SIG1_ROT_A_32 = 17;
  localparam int SIG1_ROT_B_32 = 19;
  localparam int SIG1_SHR_32   = 10;

  localparam int SIG0_ROT_A_64 = 1;
  localparam int SIG0_ROT_B_64 = 8;
  localparam int SIG0_SHR_64   = 7;
  localparam int SIG1_ROT_A_64 = 19;
  localparam int SIG1_ROT_B_64 = 61;
  localparam int SIG1_SHR_64   = 6;

  function automatic int rounds_for(input int width);
    return (width == 32) ? 64 : 80;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha2_sigma_eddsa.sv
// Combinational SHA-2 small-sigma pair; sig0 operates on x0, sig1 on x1.
// Zero latency, no flow control.
module sha2_sigma_eddsa
  import sha2_eddsa_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] sig0,
  output logic [WIDTH-1:0] sig1
);

  localparam int S0A = (WIDTH == 32) ? SIG0_ROT_A_32 : SIG0_ROT_A_64;
  localparam int S0B = (WIDTH == 32) ? SIG0_ROT_B_32 : SIG0_ROT_B_64;
  localparam int S0S = (WIDTH == 32) ? SIG0_SHR_32   : SIG0_SHR_64;
  localparam int S1A = (WIDTH == 32) ? SIG1_ROT_A_32 : SIG1_ROT_A_64;
  localparam int S1B = (WIDTH == 32) ? SIG1_ROT_B_32 : SIG1_ROT_B_64;
  localparam int S1S = (WIDTH == 32) ? SIG1_SHR_32   : SIG1_SHR_64;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  assign sig0 = rotr(x0, S0A) ^ rotr(x0, S0B) ^ (x0 >> S0S);
  assign sig1 = rotr(x1, S1A) ^ rotr(x1, S1B) ^ (x1 >> S1S);

endmodule

// File: rtl/sha2_wsched_ctrl_eddsa.sv
// SHA-2 message-schedule controller: loads 16 words, then streams W[t] with k_addr=t;
// out_valid one cycle after the 16th word, stalls hold state. Optional abort: SHA2_WSCHED_ABORT_EN.
module sha2_wsched_ctrl_eddsa
  import sha2_eddsa_pkg::*;
#(
  parameter  int WIDTH  = 64,
  localparam int ROUNDS = rounds_for(WIDTH),
  localparam int AW     = clog2(ROUNDS - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SHA2_WSCHED_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w_out,
  output logic [AW-1:0]    k_addr,
  output logic             busy,
  output logic             done
);

  wsched_state_t    state;
  logic [WIDTH-1:0] wbuf [16];
  logic [3:0]       lc;
  logic [AW-1:0]    t;
  logic             kill;

`ifdef SHA2_WSCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  logic [3:0]       t4, i2, i7, i15;
  logic [WIDTH-1:0] sig0, sig1, sched;

  assign t4  = t[3:0];
  assign i2  = t4 - 4'd2;
  assign i7  = t4 - 4'd7;
  assign i15 = t4 - 4'd15;

  sha2_sigma_eddsa #(.WIDTH(WIDTH)) u_sigma (
    .x0   (wbuf[i15]),
    .x1   (wbuf[i2]),
    .sig0 (sig0),
    .sig1 (sig1)
  );

  // The slot at t&15 still holds W[t-16] until this round's handshake overwrites it.
  assign sched  = sig1 + wbuf[i7] + sig0 + wbuf[t4];
  assign w_out  = (t < AW'(16)) ? wbuf[t4] : sched;
  assign k_addr = t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lc        <= '0;
      t         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          t <= '0;
          if (start) begin
            state    <= ST_LOAD;
            lc       <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (kill) begin
            state    <= ST_IDLE;
            lc       <= '0;
            t        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid && in_ready) begin
            wbuf[lc] <= in_data;
            lc       <= lc + 4'd1;
            if (lc == 4'd15) begin
              state     <= ST_RUN;
              t         <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (kill) begin
            state     <= ST_IDLE;
            lc        <= '0;
            t         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_valid && out_ready) begin
            wbuf[t4] <= w_out;
            if (t == AW'(ROUNDS - 1)) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              t <= t + AW'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
